// File: rtl/jal_ras_ctrl.sv
// Return-address stack controller for the multicycle CPU.
// Captures committed JAL link PCs in a circular LIFO and presents the predicted
// JR target on top_pc. Optional feature macro: RAS_STATS_EN adds saturating
// push/pop event counters (push_cnt, pop_cnt).
module jal_ras_ctrl #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [31:0]      push_pc,
  input  logic             pop,
  input  logic             flush,
  output logic [31:0]      top_pc,
  output logic [PTR_W:0]   count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
`ifdef RAS_STATS_EN
  ,
  output logic [15:0]      push_cnt,
  output logic [15:0]      pop_cnt
`endif
);

  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STAT_W = 16;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]  wp;
  logic [PTR_W-1:0]  wp_nxt;
  logic [PTR_W-1:0]  wp_m1;
  logic [PTR_W-1:0]  wp_m2;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [DATA_W-1:0] top_nxt;
  logic              ovf_nxt;
  logic              udf_nxt;
  logic              mem_we;
  logic [PTR_W-1:0]  mem_wa;
  logic              is_full;
  logic              is_empty;
  logic              push_evt;
  logic              pop_evt;

  assign wp_m1    = wp - PTR_W'(1);
  assign wp_m2    = wp - PTR_W'(2);
  assign is_full  = (count == CNT_W'(DEPTH));
  assign is_empty = (count == '0);

  // Next-state decode; priority flush > push&pop > push > pop
  always_comb begin
    wp_nxt   = wp;
    cnt_nxt  = count;
    top_nxt  = top_pc;
    ovf_nxt  = overflow;
    udf_nxt  = 1'b0;
    mem_we   = 1'b0;
    mem_wa   = wp;
    push_evt = 1'b0;
    pop_evt  = 1'b0;
    if (flush) begin
      cnt_nxt = '0;
      top_nxt = '0;
    end else if (push && pop && !is_empty) begin
      // Replace the top in place; depth unchanged
      mem_we   = 1'b1;
      mem_wa   = wp_m1;
      top_nxt  = push_pc;
      push_evt = 1'b1;
      pop_evt  = 1'b1;
    end else if (push) begin
      // Plain push (also push&pop on an empty stack); oldest entry lost when full
      mem_we   = 1'b1;
      mem_wa   = wp;
      wp_nxt   = wp + PTR_W'(1);
      top_nxt  = push_pc;
      push_evt = 1'b1;
      if (is_full) begin
        ovf_nxt = 1'b1;
      end else begin
        cnt_nxt = count + CNT_W'(1);
      end
    end else if (pop) begin
      if (is_empty) begin
        udf_nxt = 1'b1;
      end else begin
        wp_nxt  = wp_m1;
        cnt_nxt = count - CNT_W'(1);
        top_nxt = (count >= CNT_W'(2)) ? mem[wp_m2] : '0;
        pop_evt = 1'b1;
      end
    end
  end

  // Control and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp        <= '0;
      count     <= '0;
      top_pc    <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wp        <= wp_nxt;
      count     <= cnt_nxt;
      top_pc    <= top_nxt;
      empty     <= (cnt_nxt == '0);
      full      <= (cnt_nxt == CNT_W'(DEPTH));
      overflow  <= ovf_nxt;
      underflow <= udf_nxt;
    end
  end

  // Stack storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= push_pc;
    end
  end

`ifdef RAS_STATS_EN
  // Saturating event counters, cleared by reset only
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push_cnt <= '0;
      pop_cnt  <= '0;
    end else begin
      if (push_evt && (push_cnt != '1)) begin
        push_cnt <= push_cnt + STAT_W'(1);
      end
      if (pop_evt && (pop_cnt != '1)) begin
        pop_cnt <= pop_cnt + STAT_W'(1);
      end
    end
  end
`else
  // Event strobes only feed the optional counters
  logic unused_evt;
  assign unused_evt = push_evt ^ pop_evt ^ (STAT_W == 0);
`endif

endmodule

// File: tb/tb_jal_ras_ctrl.sv
// Scoreboard bench for jal_ras_ctrl (DEPTH=8): stimulus queues hand-computed
// expectations, a monitor pops and compares one per clock after the edge.
module tb_jal_ras_ctrl;

  logic        clk;
  logic        reset;
  logic        push;
  logic [31:0] push_pc;
  logic        pop;
  logic        flush;
  logic [31:0] top_pc;
  logic [3:0]  count;
  logic        empty;
  logic        full;
  logic        overflow;
  logic        underflow;
`ifdef RAS_STATS_EN
  logic [15:0] push_cnt;
  logic [15:0] pop_cnt;
`endif

  jal_ras_ctrl #(.DEPTH(8), .PTR_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_pc   (push_pc),
    .pop       (pop),
    .flush     (flush),
    .top_pc    (top_pc),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
`ifdef RAS_STATS_EN
    ,
    .push_cnt  (push_cnt),
    .pop_cnt   (pop_cnt)
`endif
  );

  typedef struct {
    string       name;
    logic [31:0] top;
    int          cnt;
    logic        ovf;
    logic        udf;
    logic        stats_zero;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle of strobes and queue the state expected after the next edge
  task automatic step(input logic ps, input logic [31:0] pc, input logic pp, input logic fl,
                      input logic [31:0] et, input int ec, input logic eo, input logic eu,
                      input string name);
    exp_t e;
    @(negedge clk);
    push = ps; push_pc = pc; pop = pp; flush = fl;
    e.name = name; e.top = et; e.cnt = ec; e.ovf = eo; e.udf = eu; e.stats_zero = 1'b0;
    sbq.push_back(e);
  endtask

  // Monitor: compare every field of the oldest expectation after each edge
  initial begin
    exp_t e;
    while (!done) begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk({e.name, ".top_pc"},    top_pc,               e.top);
        chk({e.name, ".count"},     32'(count),           32'(e.cnt));
        chk({e.name, ".empty"},     32'(empty),           32'(e.cnt == 0));
        chk({e.name, ".full"},      32'(full),            32'(e.cnt == 8));
        chk({e.name, ".overflow"},  32'(overflow),        32'(e.ovf));
        chk({e.name, ".underflow"}, 32'(underflow),       32'(e.udf));
`ifdef RAS_STATS_EN
        if (e.stats_zero) begin
          chk({e.name, ".push_cnt"}, 32'(push_cnt), 32'd0);
          chk({e.name, ".pop_cnt"},  32'(pop_cnt),  32'd0);
        end
`endif
      end
    end
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Directed stimulus
  initial begin
    exp_t e;
    reset = 1'b1; push = 1'b0; push_pc = '0; pop = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 32'h0, 0, 0, 0, "t1_idle");

    // 2: basic push/pop
    step(1, 32'h0040_0010, 0, 0, 32'h0040_0010, 1, 0, 0, "t2_push1");
    step(1, 32'h0040_0020, 0, 0, 32'h0040_0020, 2, 0, 0, "t2_push2");
    step(0, 0, 1, 0, 32'h0040_0010, 1, 0, 0, "t2_pop1");
    step(0, 0, 1, 0, 32'h0, 0, 0, 0, "t2_pop2");

    // 3: overflow wraps over the oldest entry
    for (int i = 1; i <= 8; i++) step(1, 32'(i * 'h100), 0, 0, 32'(i * 'h100), i, 0, 0, "t3_fill");
    step(1, 32'h900, 0, 0, 32'h900, 8, 1, 0, "t3_over");
    for (int k = 1; k <= 7; k++) step(0, 0, 1, 0, 32'((9 - k) * 'h100), 8 - k, 1, 0, "t3_drain");
    step(0, 0, 1, 0, 32'h0, 0, 1, 0, "t3_last");

    // 4: underflow pulse
    step(0, 0, 1, 0, 32'h0, 0, 1, 1, "t4_udf");
    step(0, 0, 0, 0, 32'h0, 0, 1, 0, "t4_idle");

    // 5: replace top
    step(1, 32'h10, 0, 0, 32'h10, 1, 1, 0, "t5_push");
    step(1, 32'h20, 0, 0, 32'h20, 2, 1, 0, "t5_push");
    step(1, 32'h30, 0, 0, 32'h30, 3, 1, 0, "t5_push");
    step(1, 32'h77, 1, 0, 32'h77, 3, 1, 0, "t5_repl");
    step(0, 0, 1, 0, 32'h20, 2, 1, 0, "t5_pop");
    step(0, 0, 1, 0, 32'h10, 1, 1, 0, "t5_pop");
    step(0, 0, 1, 0, 32'h0, 0, 1, 0, "t5_pop");

    // 6: flush beats push, then push&pop on empty, then async reset pulse
    for (int i = 1; i <= 4; i++) step(1, 32'(32'hA0 + i), 0, 0, 32'(32'hA0 + i), i, 1, 0, "t6_fill");
    step(1, 32'hBB, 0, 1, 32'h0, 0, 1, 0, "t6_flush");
    step(0, 0, 1, 1, 32'h0, 0, 1, 0, "t6_flush_pop");
    step(1, 32'hC1, 0, 0, 32'hC1, 1, 1, 0, "t6_push");
    step(0, 0, 1, 0, 32'h0, 0, 1, 0, "t6_pop");
    step(1, 32'hD1, 1, 0, 32'hD1, 1, 1, 0, "t6_pp_empty");
    step(1, 32'hE1, 0, 0, 32'hE1, 2, 1, 0, "t6_push");
    step(0, 0, 1, 0, 32'hD1, 1, 1, 0, "t6_pop");

    // Reset pulse lies entirely between clock edges
    @(negedge clk);
    push = 1'b0; pop = 1'b0; flush = 1'b0;
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    e.name = "t6_async_rst"; e.top = '0; e.cnt = 0; e.ovf = 1'b0; e.udf = 1'b0; e.stats_zero = 1'b1;
    sbq.push_back(e);
    step(0, 0, 0, 0, 32'h0, 0, 0, 0, "t6_after_rst");

    repeat (3) @(negedge clk);
    done = 1;
  end

endmodule
